wafer_defect_classifier_argmax: RTL and testbench

- Final inference stage. Sits directly downstream of the 128→9 dense layer and consumes its 9 signed 32-bit logits.
- Triggers the upstream layer, then waits for its done level.
- Scans the logits sequentially through the upstream read port and produces a class index, the winning score, and a top-1 vs top-2 margin.
- Flags whether the winner is a defect class; results are held for the RISC-V SoC.

---
 rtl/wafer_cnn_pkg.sv | 49 ++++
 rtl/wafer_defect_classifier_argmax_top2_tracker.sv | 54 +++++
 rtl/wafer_defect_classifier_argmax.sv | 120 ++++++++++++
 tb/tb_wafer_defect_classifier_argmax.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/wafer_cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wafer_cnn_pkg
// Brief    : Shared sizes, class indices, FSM states and margin helper.
// Revision : 1.0
// ============================================================================
package wafer_cnn_pkg;

    localparam int NUM_CLASSES = 9;
    localparam int NONE_CLASS  = 8;
    localparam int LOGIT_W     = 32;
    localparam int CLASS_IDX_W = 4;

    typedef enum logic [CLASS_IDX_W-1:0] {
        CENTER    = 4'd0,
        DONUT     = 4'd1,
        EDGE_LOC  = 4'd2,
        EDGE_RING = 4'd3,
        LOC       = 4'd4,
        NEAR_FULL = 4'd5,
        RANDOM    = 4'd6,
        SCRATCH   = 4'd7,
        NONE      = 4'd8
    } wafer_class_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT_UP = 3'd2,
        ST_SCAN    = 3'd3,
        ST_FINISH  = 3'd4,
        ST_DONE    = 3'd5
    } argmax_state_e;

    // best >= second always holds, so the 33-bit difference is non-negative;
    // anything that no longer fits in 31 magnitude bits saturates.
    function automatic logic [LOGIT_W-1:0] sat_margin(
        input logic signed [LOGIT_W-1:0] best,
        input logic signed [LOGIT_W-1:0] second
    );
        logic signed [LOGIT_W:0] diff;
        diff = {best[LOGIT_W-1], best} - {second[LOGIT_W-1], second};
        if (diff[LOGIT_W] || diff[LOGIT_W-1])
            return {1'b0, {(LOGIT_W-1){1'b1}}};
        return diff[LOGIT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wafer_defect_classifier_argmax_top2_tracker.sv
`default_nettype none
// ============================================================================
// Module   : top2_tracker
// Brief    : Streaming best/second-best tracker with index of the best value.
// Revision : 1.0
// ============================================================================
module top2_tracker
    import wafer_cnn_pkg::*;
(
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          clear,
    input  logic                          valid,
    input  logic [CLASS_IDX_W-1:0]        idx,
    input  logic signed [LOGIT_W-1:0]     data,
    output logic signed [LOGIT_W-1:0]     best,
    output logic signed [LOGIT_W-1:0]     second,
    output logic [CLASS_IDX_W-1:0]        best_idx
);

    localparam logic signed [LOGIT_W-1:0] c_min = {1'b1, {(LOGIT_W-1){1'b0}}};

    logic signed [LOGIT_W-1:0] r_best;
    logic signed [LOGIT_W-1:0] r_second;
    logic [CLASS_IDX_W-1:0]    r_best_idx;

    // Clearing both to the most negative value makes the first sample land in
    // best with second left at the minimum, without a special first-cycle path.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_best     <= '0;
            r_second   <= '0;
            r_best_idx <= '0;
        end else if (clear) begin
            r_best     <= c_min;
            r_second   <= c_min;
            r_best_idx <= '0;
        end else if (valid) begin
            if (data > r_best) begin
                r_second   <= r_best;
                r_best     <= data;
                r_best_idx <= idx;
            end else if (data > r_second) begin
                r_second   <= data;
            end
        end
    end

    assign best     = r_best;
    assign second   = r_second;
    assign best_idx = r_best_idx;

endmodule
`default_nettype wire

// File: rtl/wafer_defect_classifier_argmax.sv
`default_nettype none
// ============================================================================
// Module   : wafer_defect_classifier_argmax
// Brief    : Triggers the dense layer, scans its logits, holds argmax results.
// Revision : 1.0
// ============================================================================
module wafer_defect_classifier_argmax
    import wafer_cnn_pkg::*;
#(
    parameter int NUM_CLASSES = wafer_cnn_pkg::NUM_CLASSES,
    parameter int NONE_CLASS  = wafer_cnn_pkg::NONE_CLASS
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   start,
    output logic                   done,
    output logic                   up_start,
    input  logic                   up_done,
    output logic [CLASS_IDX_W-1:0] logit_addr,
    input  logic [LOGIT_W-1:0]     logit_data,
    output logic [CLASS_IDX_W-1:0] class_idx,
    output logic [LOGIT_W-1:0]     class_score,
    output logic [LOGIT_W-1:0]     margin,
    output logic                   is_defect
);

    localparam logic [CLASS_IDX_W-1:0] c_last_idx = CLASS_IDX_W'(NUM_CLASSES - 1);
    localparam logic [CLASS_IDX_W-1:0] c_none_idx = CLASS_IDX_W'(NONE_CLASS);

    argmax_state_e             r_state;
    logic                      r_done;
    logic                      r_up_start;
    logic [CLASS_IDX_W-1:0]    r_scan_idx;
    logic [CLASS_IDX_W-1:0]    r_class_idx;
    logic [LOGIT_W-1:0]        r_class_score;
    logic [LOGIT_W-1:0]        r_margin;
    logic                      r_is_defect;

    logic signed [LOGIT_W-1:0] w_best;
    logic signed [LOGIT_W-1:0] w_second;
    logic [CLASS_IDX_W-1:0]    w_best_idx;

    top2_tracker u_top2 (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (r_state == ST_REQ),
        .valid    (r_state == ST_SCAN),
        .idx      (r_scan_idx),
        .data     ($signed(logit_data)),
        .best     (w_best),
        .second   (w_second),
        .best_idx (w_best_idx)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_done        <= 1'b0;
            r_up_start    <= 1'b0;
            r_scan_idx    <= '0;
            r_class_idx   <= '0;
            r_class_score <= '0;
            r_margin      <= '0;
            r_is_defect   <= 1'b0;
        end else begin
            r_up_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_up_start <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    r_scan_idx <= '0;
                    r_state    <= ST_WAIT_UP;
                end
                // up_done is a level; a stale high from a previous run counts as ready
                ST_WAIT_UP: begin
                    if (up_done)
                        r_state <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (r_scan_idx == c_last_idx) begin
                        r_scan_idx <= '0;
                        r_state    <= ST_FINISH;
                    end else begin
                        r_scan_idx <= r_scan_idx + 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_class_idx   <= w_best_idx;
                    r_class_score <= w_best;
                    r_margin      <= sat_margin(w_best, w_second);
                    r_is_defect   <= (w_best_idx != c_none_idx);
                    r_done        <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    if (start) begin
                        r_done     <= 1'b0;
                        r_up_start <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign done        = r_done;
    assign up_start    = r_up_start;
    assign logit_addr  = r_scan_idx;
    assign class_idx   = r_class_idx;
    assign class_score = r_class_score;
    assign margin      = r_margin;
    assign is_defect   = r_is_defect;

endmodule
`default_nettype wire

// File: tb/tb_wafer_defect_classifier_argmax.sv
`default_nettype none
// ============================================================================
// Module   : tb_wafer_defect_classifier_argmax
// Brief    : Directed and randomized checks of the argmax stage against a model.
// Revision : 1.0
// ============================================================================
module tb_wafer_defect_classifier_argmax;

    localparam int N      = 9;
    localparam int NONE_I = 8;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        done;
    logic        up_start;
    logic        up_done;
    logic [3:0]  logit_addr;
    logic [31:0] logit_data;
    logic [3:0]  class_idx;
    logic [31:0] class_score;
    logic [31:0] margin;
    logic        is_defect;

    int mem [16];
    int err_cnt = 0;
    int chk_cnt = 0;

    assign logit_data = mem[logit_addr];

    wafer_defect_classifier_argmax dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .done        (done),
        .up_start    (up_start),
        .up_done     (up_done),
        .logit_addr  (logit_addr),
        .logit_data  (logit_data),
        .class_idx   (class_idx),
        .class_score (class_score),
        .margin      (margin),
        .is_defect   (is_defect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: first index of the maximum wins; second is the largest of the
    // remaining eight values, so a tie with the winner yields a zero margin.
    task automatic model(input int l[N], output int idx, output int score, output longint marg);
        int top2;
        idx = 0;
        for (int i = 1; i < N; i++)
            if (l[i] > l[idx]) idx = i;
        top2 = int'(32'h8000_0000);
        for (int i = 0; i < N; i++)
            if (i != idx && l[i] > top2) top2 = l[i];
        score = l[idx];
        marg  = longint'(score) - longint'(top2);
        if (marg > 64'h7FFF_FFFF) marg = 64'h7FFF_FFFF;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // delay == 0: up_done already high at start; otherwise held low that many
    // WAIT_UP cycles, with an ignored start pulse in the middle of long waits.
    task automatic run(input string name, input int l[N], input int delay);
        int     e_idx, e_score, pulses, early_done, addr_moved;
        longint e_marg;
        model(l, e_idx, e_score, e_marg);
        for (int i = 0; i < N; i++) mem[i] = l[i];
        pulses = 0; early_done = 0; addr_moved = 0;
        start = 1'b1;
        if (delay > 0) up_done = 1'b0; else up_done = 1'b1;
        step();
        start = 1'b0;
        check_val({name, ":up_start_t1"}, longint'(up_start), 1);
        check_val({name, ":done_cleared"}, longint'(done), 0);
        pulses += int'(up_start);
        step();
        pulses += int'(up_start);
        for (int w = 0; w < delay; w++) begin
            if (logit_addr != 4'd0) addr_moved++;
            if (done) early_done++;
            start = (w == 5);
            step();
            pulses += int'(up_start);
        end
        start = 1'b0;
        if (delay > 0) check_val({name, ":addr_held"}, addr_moved, 0);
        up_done = 1'b1;
        for (int c = 1; c <= 11; c++) begin
            step();
            pulses += int'(up_start);
            if (c < 11 && done) early_done++;
        end
        check_val({name, ":early_done"}, early_done, 0);
        check_val({name, ":done"}, longint'(done), 1);
        check_val({name, ":up_start_pulses"}, pulses, 1);
        check_val({name, ":class_idx"}, longint'(class_idx), e_idx);
        check_val({name, ":class_score"}, longint'($signed(class_score)), e_score);
        check_val({name, ":margin"}, longint'(margin), e_marg);
        check_val({name, ":is_defect"}, longint'(is_defect), longint'(e_idx != NONE_I));
    endtask

    task automatic check_all_zero(input string name);
        check_val({name, ":done"}, longint'(done), 0);
        check_val({name, ":up_start"}, longint'(up_start), 0);
        check_val({name, ":logit_addr"}, longint'(logit_addr), 0);
        check_val({name, ":class_idx"}, longint'(class_idx), 0);
        check_val({name, ":class_score"}, longint'(class_score), 0);
        check_val({name, ":margin"}, longint'(margin), 0);
        check_val({name, ":is_defect"}, longint'(is_defect), 0);
    endtask

    initial begin
        int l[N];
        int mn;
        mn = int'(32'h8000_0000);
        for (int i = 0; i < 16; i++) mem[i] = 0;
        resetn = 1'b0; start = 1'b0; up_done = 1'b0;
        repeat (3) step();
        check_all_zero("reset");
        resetn = 1'b1;
        step();

        l = '{5, -3, 100, 7, 0, -50, 99, 1, 2};
        run("distinct", l, 0);
        l = '{-10, -10, -10, -10, -10, -10, -10, -10, -10};
        run("all_equal", l, 0);
        l = '{1, 2, 3, 30, -5, 0, 10, 20, 40};
        run("none_class", l, 0);
        l = '{32'h7FFF_FFFF, mn, mn, mn, mn, mn, mn, mn, mn};
        run("saturate", l, 0);
        l = '{-7, 12, 12, 3, -1, 11, 0, 4, 12};
        run("handshake", l, 20);

        // Abort during SCAN k=4 (cycle T+7), then rerun with fresh logits.
        for (int i = 0; i < N; i++) mem[i] = 1000 - i;
        up_done = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        check_val("abort:addr_k4", longint'(logit_addr), 4);
        resetn = 1'b0;
        step();
        check_all_zero("abort");
        resetn = 1'b1;
        l = '{-4, -9, -2, -8, -6, -3, -5, -7, -1};
        run("after_abort", l, 0);
        l = '{3, 3, 1, 9, 2, 2, 8, 0, 9};
        run("restart_done", l, 2);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++) begin
                if (t[0]) l[i] = int'($urandom);
                else      l[i] = int'($urandom_range(0, 6)) - 3;
            end
            run($sformatf("rand%0d", t), l, int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
